// File: rtl/wbq_pkg.sv
// wbq_pkg: shared widths and entry type for the writeback queue
package wbq_pkg;
  localparam int WBQ_AW = 5;
  localparam int WBQ_DW = 32;
  typedef struct packed {
    logic [WBQ_AW-1:0] address;
    logic [WBQ_DW-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_match.sv
// wbq_match: finds the youngest occupied entry matching one lookup address
module wbq_match #(
  parameter int DEPTH = 4,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic [AW-1:0]            addrs [DEPTH],
  input  logic [DW-1:0]            datas [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            lookup,
  output logic                     hit,
  output logic [DW-1:0]            hit_data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // walk oldest to youngest so the last match seen is the youngest one
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (lookup != '0 && (PW+1)'(i) < count && addrs[idx] == lookup) begin
        hit = 1'b1;
        hit_data = datas[idx];
      end
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: buffers register-file writes and drains one per cycle
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = WBQ_AW,
  parameter int DW = WBQ_DW
) (
  input  logic                     SYS_clk,
  input  logic                     SYS_reset,
  input  logic                     WBQ_valid_in,
  output logic                     WBQ_ready_out,
  input  logic [AW-1:0]            WBQ_address_in,
  input  logic [DW-1:0]            WBQ_data_in,
  output logic                     WBQ_write_out,
  output logic [AW-1:0]            WBQ_address_wr,
  output logic [DW-1:0]            WBQ_data_wb_out,
  input  logic [AW-1:0]            WBQ_lookup_address1,
  input  logic [AW-1:0]            WBQ_lookup_address2,
  output logic                     WBQ_hit1,
  output logic                     WBQ_hit2,
  output logic [DW-1:0]            WBQ_hit_data1,
  output logic [DW-1:0]            WBQ_hit_data2,
  output logic [$clog2(DEPTH):0]   WBQ_count,
  output logic                     WBQ_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head, tail;
  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic push, pop;
  assign WBQ_ready_out   = WBQ_count != CW'(DEPTH);
  assign WBQ_empty       = WBQ_count == '0;
  assign pop             = !WBQ_empty;
  assign push            = WBQ_valid_in && WBQ_ready_out && WBQ_address_in != '0;
  assign WBQ_write_out   = pop;
  assign WBQ_address_wr  = pop ? mem_addr[head] : '0;
  assign WBQ_data_wb_out = pop ? mem_data[head] : '0;
  // pointer and occupancy bookkeeping; head retires as the register file commits it
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      head <= '0;
      tail <= '0;
      WBQ_count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      WBQ_count <= WBQ_count + CW'(push) - CW'(pop);
    end
  end
  // storage is never cleared; occupancy alone decides which slots are live
  always_ff @(posedge SYS_clk) begin
    if (push) begin
      mem_addr[tail] <= WBQ_address_in;
      mem_data[tail] <= WBQ_data_in;
    end
  end
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match1 (
    .addrs(mem_addr), .datas(mem_data), .head(head), .count(WBQ_count),
    .lookup(WBQ_lookup_address1), .hit(WBQ_hit1), .hit_data(WBQ_hit_data1)
  );
  wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match2 (
    .addrs(mem_addr), .datas(mem_data), .head(head), .count(WBQ_count),
    .lookup(WBQ_lookup_address2), .hit(WBQ_hit2), .hit_data(WBQ_hit_data2)
  );
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: randomized scoreboard bench for the writeback queue
module tb_wb_write_queue;
  import wbq_pkg::*;
  localparam int DEPTH = 4;
  logic SYS_clk = 0, SYS_reset = 1;
  logic valid = 0, ready, write_out, hit1, hit2, empty;
  logic [4:0] addr_in = 0, addr_wr, l1 = 0, l2 = 0;
  logic [31:0] data_in = 0, data_wb, hd1, hd2;
  logic [2:0] count;
  int compared = 0, mismatched = 0;
  bit started = 0;
  wbq_entry_t mq[$];
  wbq_entry_t sb[$];

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .WBQ_valid_in(valid), .WBQ_ready_out(ready),
    .WBQ_address_in(addr_in), .WBQ_data_in(data_in),
    .WBQ_write_out(write_out), .WBQ_address_wr(addr_wr), .WBQ_data_wb_out(data_wb),
    .WBQ_lookup_address1(l1), .WBQ_lookup_address2(l2),
    .WBQ_hit1(hit1), .WBQ_hit2(hit2), .WBQ_hit_data1(hd1), .WBQ_hit_data2(hd2),
    .WBQ_count(count), .WBQ_empty(empty)
  );

  always #5 SYS_clk = ~SYS_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] lookup(input logic [4:0] la);
    if (la == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].address == la) return {1'b1, mq[i].data};
    return '0;
  endfunction

  task automatic step(input logic r, input logic v, input logic [4:0] a,
                      input logic [31:0] d, input logic [4:0] la1, input logic [4:0] la2);
    logic [32:0] e1, e2;
    bit acc;
    e1 = lookup(l1);
    e2 = lookup(l2);
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("ready", 32'(ready), 32'(mq.size() != DEPTH));
    chk("write_out", 32'(write_out), 32'(mq.size() != 0));
    chk("hit1", 32'(hit1), 32'(e1[32]));
    chk("hit_data1", hd1, e1[31:0]);
    chk("hit2", 32'(hit2), 32'(e2[32]));
    chk("hit_data2", hd2, e2[31:0]);
    SYS_reset = r; valid = v; addr_in = a; data_in = d; l1 = la1; l2 = la2;
    acc = v && mq.size() != DEPTH;
    @(posedge SYS_clk);
    if (r) begin
      mq.delete();
      sb.delete();
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (acc && a != 0) begin
        mq.push_back('{address: a, data: d});
        sb.push_back('{address: a, data: d});
      end
    end
    @(negedge SYS_clk);
  endtask

  // monitor: every write-port beat must match the next expected write in order
  always @(negedge SYS_clk) begin
    if (started) begin
      if (write_out === 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL wr_unexpected: got addr %h data %h expected no write", addr_wr, data_wb);
        end else begin
          wbq_entry_t e;
          e = sb.pop_front();
          chk("wr_addr", 32'(addr_wr), 32'(e.address));
          chk("wr_data", data_wb, e.data);
        end
      end else begin
        chk("idle_addr", 32'(addr_wr), 0);
        chk("idle_data", data_wb, 0);
      end
    end
  end

  initial begin
    @(posedge SYS_clk);
    @(negedge SYS_clk);
    mq.delete();
    started = 1;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 32'hAAAA_0001, 3, 0);
    step(0, 0, 0, 0, 3, 0);
    step(0, 1, 0, 32'h0000_DEAD, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) step(0, 1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(i - 1));
    step(0, 1, 5, 32'h10, 5, 0);
    step(0, 1, 5, 32'h20, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    step(0, 1, 7, 32'h77, 7, 7);
    step(1, 1, 9, 32'h99, 7, 9);
    step(0, 0, 0, 0, 7, 9);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
           $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
